// File: rtl/mole_hit_detector.sv
// Switch front end for the whack-a-mole game: synchronises and debounces the player switches,
// scores debounced toggles against the lit moles and reports hits/misses once per round.
module mole_hit_detector #(
    parameter int NUM_SW    = 8,
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw,
    input  logic              round_tick,
    input  logic [NUM_SW-1:0] mole_mask,
    output logic              hit_valid,
    input  logic              hit_ready,
    output logic [NUM_SW-1:0] hit_mask,
    output logic [3:0]        hit_count,
    output logic [3:0]        miss_count,
    output logic              report_lost
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    function automatic logic [3:0] popcount(input logic [NUM_SW-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NUM_SW; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    state_t              state_r, state_nx_s;
    logic [NUM_SW-1:0]   sync1_r, sync2_r, stable_r;
    logic [DB_W-1:0]     db_cnt_r [NUM_SW];
    logic [DB_W-1:0]     init_cnt_r;
    logic [NUM_SW-1:0]   accept_s, toggle_s;
    logic [NUM_SW-1:0]   hit_acc_r, miss_acc_r, mole_cur_r;
    logic [NUM_SW-1:0]   hits_s, misses_s;
    logic                init_done_s;
    logic                load_s, drop_s, ack_s, accum_s, mole_ld_s;
    logic                hit_valid_r, report_lost_r;
    logic [NUM_SW-1:0]   hit_mask_r;
    logic [3:0]          hit_count_r, miss_count_r;

    // Two-flop synchroniser for the asynchronous switch pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= sw;
            sync2_r <= sync1_r;
        end
    end

    // A bit is accepted once it has disagreed with the stable value for DB_CYCLES cycles
    always_comb begin
        accept_s = '0;
        toggle_s = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            accept_s[i] = (sync2_r[i] != stable_r[i]) && (db_cnt_r[i] == DB_LAST);
        end
        if (state_r != ST_INIT) begin
            toggle_s = accept_s;
        end else begin
            toggle_s = '0;
        end
    end

    // Per-bit debounce counters and stable state; INIT copies the synced pins so power-up levels are not whacks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else if (state_r == ST_INIT) begin
            stable_r <= sync2_r;
            for (int i = 0; i < NUM_SW; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (accept_s[i]) begin
                    stable_r[i] <= sync2_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    assign init_done_s = (init_cnt_r == DB_LAST);

    // Settling timer that holds the FSM in INIT for DB_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt_r <= '0;
        end else if ((state_r == ST_INIT) && !init_done_s) begin
            init_cnt_r <= init_cnt_r + DB_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        drop_s     = 1'b0;
        ack_s      = 1'b0;
        accum_s    = 1'b0;
        mole_ld_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                mole_ld_s = round_tick;
                if (init_done_s) begin
                    state_nx_s = ST_ARMED;
                end else begin
                    state_nx_s = ST_INIT;
                end
            end
            ST_ARMED: begin
                accum_s = 1'b1;
                if (round_tick) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_REPORT;
                end else begin
                    state_nx_s = ST_ARMED;
                end
            end
            ST_REPORT: begin
                accum_s = 1'b1;
                if (round_tick && hit_ready) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_REPORT;
                end else if (round_tick) begin
                    drop_s     = 1'b1;
                    state_nx_s = ST_REPORT;
                end else if (hit_ready) begin
                    ack_s      = 1'b1;
                    state_nx_s = ST_ARMED;
                end else begin
                    state_nx_s = ST_REPORT;
                end
            end
            default: begin
                state_nx_s = ST_INIT;
            end
        endcase
    end

    // Same-cycle toggles are folded in so a whack on the round_tick cycle is not lost
    assign hits_s   = hit_acc_r  | (toggle_s &  mole_cur_r);
    assign misses_s = miss_acc_r | (toggle_s & ~mole_cur_r);

    // Round accumulators, current mole pattern and registered report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_acc_r     <= '0;
            miss_acc_r    <= '0;
            mole_cur_r    <= '0;
            hit_valid_r   <= 1'b0;
            hit_mask_r    <= '0;
            hit_count_r   <= 4'd0;
            miss_count_r  <= 4'd0;
            report_lost_r <= 1'b0;
        end else begin
            if (load_s || drop_s || mole_ld_s) begin
                mole_cur_r <= mole_mask;
            end
            if (load_s || drop_s) begin
                hit_acc_r  <= '0;
                miss_acc_r <= '0;
            end else if (accum_s) begin
                hit_acc_r  <= hits_s;
                miss_acc_r <= misses_s;
            end
            if (load_s) begin
                hit_valid_r  <= 1'b1;
                hit_mask_r   <= hits_s;
                hit_count_r  <= popcount(hits_s);
                miss_count_r <= popcount(misses_s);
            end else if (ack_s) begin
                hit_valid_r <= 1'b0;
            end
            if (drop_s) begin
                report_lost_r <= 1'b1;
            end
        end
    end

    assign hit_valid   = hit_valid_r;
    assign hit_mask    = hit_mask_r;
    assign hit_count   = hit_count_r;
    assign miss_count  = miss_count_r;
    assign report_lost = report_lost_r;

endmodule
